// File: rtl/cpu_core_pkg.sv
// Shared encodings for cpu_core: FSM states, opcodes, memory commands, shift/ALU codes.
// Defining CPU_CORE_HALT_EN adds the S_HALT state to the state enum.
package cpu_core_pkg;

`ifdef CPU_CORE_HALT_EN
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WRI, S_GETA, S_GETB, S_ALU,
    S_WB, S_ADR, S_LDA, S_MRD, S_MWB, S_STC, S_MWR, S_HALT
  } state_t;
`else
  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WRI, S_GETA, S_GETB, S_ALU,
    S_WB, S_ADR, S_LDA, S_MRD, S_MWB, S_STC, S_MWR
  } state_t;
`endif

  localparam logic [2:0] OPC_MEMLD = 3'b011;
  localparam logic [2:0] OPC_MEMST = 3'b100;
  localparam logic [2:0] OPC_ALU   = 3'b101;
  localparam logic [2:0] OPC_MOV   = 3'b110;
  localparam logic [2:0] OPC_HALT  = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // ALU codes line up with the op field of the 101 instruction group.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_MDATA = 2'b10;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

endpackage

// File: rtl/cpu_core_datapath.sv
// cpu_core datapath: 8x16 register file, A/B/C registers, B-path shifter, ALU and CMP flags.
// Register file has a single read port and a single write port selected by the control FSM.
module cpu_core_datapath
  import cpu_core_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rf_write,
  input  logic [2:0]  i_rf_waddr,
  input  logic [1:0]  i_vsel,
  input  logic [2:0]  i_rf_raddr,
  input  logic        i_load_a,
  input  logic        i_load_b,
  input  logic        i_load_c,
  input  logic        i_load_s,
  input  logic        i_asel,
  input  logic        i_bsel,
  input  logic [1:0]  i_shift,
  input  logic [1:0]  i_alu_op,
  input  logic [15:0] i_sximm8,
  input  logic [15:0] i_sximm5,
  input  logic [15:0] i_mdata,
  output logic [15:0] o_c,
  output logic        o_n,
  output logic        o_v,
  output logic        o_z
);

  logic [7:0][15:0] w_regs;
  logic [15:0]      w_wdata;
  logic [15:0]      w_rdata;
  logic [15:0]      w_bshift;
  logic [15:0]      w_ain;
  logic [15:0]      w_bin;
  logic [15:0]      w_alu;
  logic             w_ovf;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [15:0]      r_c;
  logic             r_n;
  logic             r_v;
  logic             r_z;

  always_comb begin
    w_wdata = r_c;
    case (i_vsel)
      VSEL_IMM8:  w_wdata = i_sximm8;
      VSEL_MDATA: w_wdata = i_mdata;
      default:    w_wdata = r_c;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rf
      logic [15:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_rf_write && (i_rf_waddr == 3'(gi))) begin
          r_q <= w_wdata;
        end
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

  assign w_rdata = w_regs[i_rf_raddr];

  always_comb begin
    w_bshift = r_b;
    case (i_shift)
      SH_LSL:  w_bshift = {r_b[14:0], 1'b0};
      SH_LSR:  w_bshift = {1'b0, r_b[15:1]};
      SH_ASR:  w_bshift = {r_b[15], r_b[15:1]};
      default: w_bshift = r_b;
    endcase
  end

  assign w_ain = i_asel ? 16'h0000 : r_a;
  assign w_bin = i_bsel ? i_sximm5 : w_bshift;

  always_comb begin
    w_alu = w_ain + w_bin;
    case (i_alu_op)
      ALU_SUB: w_alu = w_ain - w_bin;
      ALU_AND: w_alu = w_ain & w_bin;
      ALU_NOT: w_alu = ~w_bin;
      default: w_alu = w_ain + w_bin;
    endcase
  end

  // Subtraction overflow: operands differ in sign and result sign differs from A.
  assign w_ovf = (w_ain[15] ^ w_bin[15]) & (w_alu[15] ^ w_ain[15]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_n <= 1'b0;
      r_v <= 1'b0;
      r_z <= 1'b0;
    end else begin
      if (i_load_a) r_a <= w_rdata;
      if (i_load_b) r_b <= w_rdata;
      if (i_load_c) r_c <= w_alu;
      if (i_load_s) begin
        r_n <= w_alu[15];
        r_v <= w_ovf;
        r_z <= (w_alu == 16'h0000);
      end
    end
  end

  assign o_c = r_c;
  assign o_n = r_n;
  assign o_v = r_v;
  assign o_z = r_z;

endmodule

// File: rtl/cpu_core.sv
// cpu_core top: instruction register, decoder, multicycle control FSM, PC and DA registers.
// Build option CPU_CORE_HALT_EN: opcode 111 enters a HALT state (w=1) left only by reset.
module cpu_core
  import cpu_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] read_data,
  output logic [8:0]  mem_addr,
  output logic [1:0]  mem_cmd,
  output logic [15:0] write_data,
  output logic [15:0] out,
  output logic        N,
  output logic        V,
  output logic        Z,
  output logic        w
);

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_pc;
  logic [8:0]  r_da;
  logic [15:0] r_ir;

  logic [2:0]  w_opcode;
  logic [1:0]  w_op;
  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [1:0]  w_sh;
  logic [2:0]  w_rm;
  logic [15:0] w_sximm8;
  logic [15:0] w_sximm5;

  logic        w_load_ir;
  logic        w_load_pc;
  logic        w_load_da;
  logic        w_addr_pc;
  logic [1:0]  w_mem_cmd;
  logic        w_rf_write;
  logic [2:0]  w_rf_waddr;
  logic [1:0]  w_vsel;
  logic [2:0]  w_rf_raddr;
  logic        w_load_a;
  logic        w_load_b;
  logic        w_load_c;
  logic        w_load_s;
  logic        w_asel;
  logic        w_bsel;
  logic [1:0]  w_shift;
  logic [1:0]  w_alu_op;
  logic [15:0] w_c;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];
  assign w_sximm8 = sext8(r_ir[7:0]);
  assign w_sximm5 = sext5(r_ir[4:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RST;
      r_pc    <= '0;
      r_da    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load_ir) r_ir <= read_data;
      if (w_load_pc) r_pc <= r_pc + 9'd1;
      if (w_load_da) r_da <= w_c[8:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_ir    = 1'b0;
    w_load_pc    = 1'b0;
    w_load_da    = 1'b0;
    w_addr_pc    = 1'b0;
    w_mem_cmd    = MEM_NONE;
    w_rf_write   = 1'b0;
    w_rf_waddr   = w_rd;
    w_vsel       = VSEL_C;
    w_rf_raddr   = w_rm;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_c     = 1'b0;
    w_load_s     = 1'b0;
    w_asel       = 1'b0;
    w_bsel       = 1'b0;
    w_shift      = SH_NONE;
    w_alu_op     = ALU_ADD;
    case (r_state)
      S_RST: w_state_next = S_IF1;
      S_IF1: begin
        w_addr_pc    = 1'b1;
        w_mem_cmd    = MEM_READ;
        w_state_next = S_IF2;
      end
      S_IF2: begin
        w_addr_pc    = 1'b1;
        w_mem_cmd    = MEM_READ;
        w_load_ir    = 1'b1;
        w_state_next = S_UPC;
      end
      S_UPC: begin
        w_load_pc    = 1'b1;
        w_state_next = S_DEC;
      end
      S_DEC: begin
        // Unrecognised encodings fall through to the next fetch.
        w_state_next = S_IF1;
        case (w_opcode)
          OPC_MOV: begin
            if (w_op == OP_MOV_IMM)      w_state_next = S_WRI;
            else if (w_op == OP_MOV_REG) w_state_next = S_GETB;
          end
          OPC_ALU:   w_state_next = (w_op == OP_MVN) ? S_GETB : S_GETA;
          OPC_MEMLD,
          OPC_MEMST: if (w_op == OP_MEM) w_state_next = S_GETA;
`ifdef CPU_CORE_HALT_EN
          OPC_HALT:  w_state_next = S_HALT;
`endif
          default: ;
        endcase
      end
      S_WRI: begin
        w_rf_write   = 1'b1;
        w_rf_waddr   = w_rn;
        w_vsel       = VSEL_IMM8;
        w_state_next = S_IF1;
      end
      S_GETA: begin
        w_rf_raddr   = w_rn;
        w_load_a     = 1'b1;
        w_state_next = (w_opcode == OPC_ALU) ? S_GETB : S_ADR;
      end
      S_GETB: begin
        w_rf_raddr   = (w_opcode == OPC_MEMST) ? w_rd : w_rm;
        w_load_b     = 1'b1;
        w_state_next = (w_opcode == OPC_MEMST) ? S_STC : S_ALU;
      end
      S_ALU: begin
        w_load_c     = 1'b1;
        w_shift      = w_sh;
        w_asel       = (w_opcode == OPC_MOV);
        w_alu_op     = (w_opcode == OPC_MOV) ? ALU_ADD : w_op;
        w_load_s     = (w_opcode == OPC_ALU) && (w_op == OP_CMP);
        w_state_next = w_load_s ? S_IF1 : S_WB;
      end
      S_WB: begin
        w_rf_write   = 1'b1;
        w_state_next = S_IF1;
      end
      S_ADR: begin
        w_bsel       = 1'b1;
        w_load_c     = 1'b1;
        w_state_next = S_LDA;
      end
      S_LDA: begin
        w_load_da    = 1'b1;
        w_state_next = (w_opcode == OPC_MEMLD) ? S_MRD : S_GETB;
      end
      S_MRD: begin
        w_mem_cmd    = MEM_READ;
        w_state_next = S_MWB;
      end
      S_MWB: begin
        w_mem_cmd    = MEM_READ;
        w_rf_write   = 1'b1;
        w_vsel       = VSEL_MDATA;
        w_state_next = S_IF1;
      end
      S_STC: begin
        w_asel       = 1'b1;
        w_load_c     = 1'b1;
        w_state_next = S_MWR;
      end
      S_MWR: begin
        w_mem_cmd    = MEM_WRITE;
        w_state_next = S_IF1;
      end
`ifdef CPU_CORE_HALT_EN
      S_HALT: w_state_next = S_HALT;
`endif
      default: w_state_next = S_RST;
    endcase
  end

  cpu_core_datapath u_datapath (
    .clk        (clk),
    .rst_n      (reset),
    .i_rf_write (w_rf_write),
    .i_rf_waddr (w_rf_waddr),
    .i_vsel     (w_vsel),
    .i_rf_raddr (w_rf_raddr),
    .i_load_a   (w_load_a),
    .i_load_b   (w_load_b),
    .i_load_c   (w_load_c),
    .i_load_s   (w_load_s),
    .i_asel     (w_asel),
    .i_bsel     (w_bsel),
    .i_shift    (w_shift),
    .i_alu_op   (w_alu_op),
    .i_sximm8   (w_sximm8),
    .i_sximm5   (w_sximm5),
    .i_mdata    (read_data),
    .o_c        (w_c),
    .o_n        (N),
    .o_v        (V),
    .o_z        (Z)
  );

  assign mem_addr   = w_addr_pc ? r_pc : r_da;
  assign mem_cmd    = w_mem_cmd;
  assign write_data = w_c;
  assign out        = w_c;

`ifdef CPU_CORE_HALT_EN
  assign w = (r_state == S_HALT);
`else
  assign w = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed testbench for cpu_core: hand-assembled programs in a bench-side RAM,
// checking fetch addresses (instruction cycle counts), results, flags, memory traffic and reset.
module tb_cpu_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] read_data;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_cmd;
  logic [15:0] write_data;
  logic [15:0] out_q;
  logic        n_f;
  logic        v_f;
  logic        z_f;
  logic        w_f;

  logic [15:0] mem [0:511];
  int          n_checks;
  int          n_fail;

  cpu_core u_dut (
    .clk        (clk),
    .reset      (rst_n),
    .read_data  (read_data),
    .mem_addr   (mem_addr),
    .mem_cmd    (mem_cmd),
    .write_data (write_data),
    .out        (out_q),
    .N          (n_f),
    .V          (v_f),
    .Z          (z_f),
    .w          (w_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign read_data = (mem_cmd == 2'b01) ? mem[mem_addr] : 16'h0000;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its IF1 and checks the next fetch lands on next_pc exactly.
  task automatic run_instr(input int cycles, input logic [8:0] next_pc, input string name);
    tick(cycles);
    n_checks++;
    if (mem_cmd !== 2'b01 || mem_addr !== next_pc) begin
      n_fail++;
      $display("FAIL %s fetch: cmd=%b addr=%03h, required cmd=01 addr=%03h", name, mem_cmd, mem_addr, next_pc);
    end
    $display("%s: %0d cycles, out=%04h N=%b V=%b Z=%b", name, cycles, out_q, n_f, v_f, z_f);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[0]  = 16'hD007;
    mem[1]  = 16'hD102;
    mem[2]  = 16'hA148;
    mem[3]  = 16'hA908;
    mem[4]  = 16'hA800;
    mem[5]  = 16'hD410;
    mem[6]  = 16'h64A0;
    mem[7]  = 16'hD601;
    mem[8]  = 16'hAD06;
    mem[9]  = 16'h8441;
    mem[10] = 16'hE000;
    mem[16] = 16'h8000;
    #2;
    n_checks++;
    if (mem_cmd !== 2'b00 || mem_addr !== 9'h000 || w_f !== 1'b0 || out_q !== 16'h0000 ||
        {n_f, v_f, z_f} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: cmd=%b addr=%03h w=%b out=%04h NVZ=%b%b%b, required 00/000/0/0000/000",
               mem_cmd, mem_addr, w_f, out_q, n_f, v_f, z_f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h000) begin
      n_fail++;
      $display("FAIL first_fetch: cmd=%b addr=%03h, required 01/000", mem_cmd, mem_addr);
    end
    $display("reset released: first fetch cmd=%b addr=%03h", mem_cmd, mem_addr);
  endtask

  task automatic test_mov_add;
    run_instr(5, 9'd1, "MOV R0,#7");
    run_instr(5, 9'd2, "MOV R1,#2");
    run_instr(8, 9'd3, "ADD R2,R1,R0,LSL#1");
    n_checks++;
    if (out_q !== 16'h0010) begin
      n_fail++;
      $display("FAIL add_result: out=%04h, required 0010", out_q);
    end
  endtask

  task automatic test_cmp;
    // 2 - (7<<1) = -12
    run_instr(7, 9'd4, "CMP R1,R0,LSL#1");
    n_checks++;
    if (out_q !== 16'hFFF4 || {n_f, v_f, z_f} !== 3'b100) begin
      n_fail++;
      $display("FAIL cmp_neg: out=%04h NVZ=%b%b%b, required FFF4/100", out_q, n_f, v_f, z_f);
    end
    run_instr(7, 9'd5, "CMP R0,R0");
    n_checks++;
    if (out_q !== 16'h0000 || {n_f, v_f, z_f} !== 3'b001) begin
      n_fail++;
      $display("FAIL cmp_zero: out=%04h NVZ=%b%b%b, required 0000/001", out_q, n_f, v_f, z_f);
    end
  endtask

  task automatic test_load;
    run_instr(5, 9'd6, "MOV R4,#16");
    tick(7);
    n_checks++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h010) begin
      n_fail++;
      $display("FAIL ldr_mrd: cmd=%b addr=%03h, required 01/010", mem_cmd, mem_addr);
    end
    tick(1);
    n_checks++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h010) begin
      n_fail++;
      $display("FAIL ldr_mwb: cmd=%b addr=%03h, required 01/010", mem_cmd, mem_addr);
    end
    run_instr(1, 9'd7, "LDR R5,[R4]");
    n_checks++;
    if (out_q !== 16'h0010) begin
      n_fail++;
      $display("FAIL ldr_addr_c: out=%04h, required 0010", out_q);
    end
    run_instr(5, 9'd8, "MOV R6,#1");
    run_instr(7, 9'd9, "CMP R5,R6");
    n_checks++;
    if (out_q !== 16'h7FFF || {n_f, v_f, z_f} !== 3'b010) begin
      n_fail++;
      $display("FAIL cmp_ovf: out=%04h NVZ=%b%b%b, required 7FFF/010", out_q, n_f, v_f, z_f);
    end
  endtask

  task automatic test_store;
    int          n_wr;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    n_wr    = 0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (mem_cmd === 2'b10) begin
        n_wr++;
        wr_addr = mem_addr;
        wr_data = write_data;
      end
    end
    n_checks++;
    if (n_wr !== 1 || wr_addr !== 9'h011 || wr_data !== 16'h0010) begin
      n_fail++;
      $display("FAIL str_write: writes=%0d addr=%03h data=%04h, required 1/011/0010", n_wr, wr_addr, wr_data);
    end
    run_instr(1, 9'd10, "STR R2,[R4,#1]");
  endtask

  task automatic test_halt;
`ifdef CPU_CORE_HALT_EN
    tick(4);
    n_checks++;
    if (w_f !== 1'b1 || mem_cmd !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_enter: w=%b cmd=%b, required 1/00", w_f, mem_cmd);
    end
    tick(5);
    n_checks++;
    if (w_f !== 1'b1 || mem_cmd !== 2'b00) begin
      n_fail++;
      $display("FAIL halt_hold: w=%b cmd=%b, required 1/00", w_f, mem_cmd);
    end
    $display("HALT: w=%b cmd=%b", w_f, mem_cmd);
`else
    run_instr(4, 9'd11, "HALT (no-op build)");
    n_checks++;
    if (w_f !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_noop_w: w=%b, required 0", w_f);
    end
`endif
  endtask

  task automatic test_reset_mid_ldr;
    @(negedge clk);
    rst_n = 1'b0;
    mem[0] = 16'hD410;
    mem[1] = 16'h64A0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    run_instr(5, 9'd1, "MOV R4,#16 (pre-reset)");
    tick(6);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_cmd !== 2'b00 || mem_addr !== 9'h000 || w_f !== 1'b0 || out_q !== 16'h0000 ||
        {n_f, v_f, z_f} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_ldr_reset: cmd=%b addr=%03h w=%b out=%04h NVZ=%b%b%b, required 00/000/0/0000/000",
               mem_cmd, mem_addr, w_f, out_q, n_f, v_f, z_f);
    end
    for (int i = 0; i < 8; i++) mem[i] = 16'hC020 | 16'(i);
    mem[8]  = 16'hB860;
    mem[9]  = 16'hD25A;
    mem[10] = 16'hB392;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (mem_cmd !== 2'b01 || mem_addr !== 9'h000) begin
      n_fail++;
      $display("FAIL pc_after_reset: cmd=%b addr=%03h, required 01/000", mem_cmd, mem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      run_instr(7, 9'(i + 1), $sformatf("MOV R1,R%0d", i));
      n_checks++;
      if (out_q !== 16'h0000) begin
        n_fail++;
        $display("FAIL reg_cleared R%0d: out=%04h, required 0000", i, out_q);
      end
    end
  endtask

  task automatic test_mvn_and;
    run_instr(7, 9'd9, "MVN R3,R0");
    n_checks++;
    if (out_q !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL mvn_result: out=%04h, required FFFF", out_q);
    end
    run_instr(5, 9'd10, "MOV R2,#0x5A");
    run_instr(8, 9'd11, "AND R4,R3,R2,LSR#1");
    n_checks++;
    if (out_q !== 16'h002D || {n_f, v_f, z_f} !== 3'b000) begin
      n_fail++;
      $display("FAIL and_result: out=%04h NVZ=%b%b%b, required 002D/000", out_q, n_f, v_f, z_f);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_mov_add();
    test_cmp();
    test_load();
    test_store();
    test_halt();
    test_reset_mid_ldr();
    test_mvn_and();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
